// File: rtl/fir_sequencer_if.sv
// fir_sequencer_if: handshake bundle between the FIR control sequencer and its
// environment (input FIFO, delay line, datapath, accumulator, output FIFO).
//   master : the sequencer; drives strobes, phase select and status
//   slave  : the environment; drives run/flush requests and FIFO flags
// Optional macro FIR_STALL_CNT_EN adds the stall_cnt status bus (STALL_W bits).
interface fir_sequencer_if
`ifdef FIR_STALL_CNT_EN
    #(parameter int unsigned STALL_W = 16)
`endif
    ;
    logic       enable;
    logic       flush;
    logic       in_empty;
    logic       PullOut;
    logic       shift_en;
    logic [1:0] count;
    logic       valid;
    logic       acc_en;
    logic       out_full;
    logic       out_push;
    logic       busy;
    logic       primed;
`ifdef FIR_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt;
`endif

    modport master (
        input  enable, flush, in_empty, out_full,
        output PullOut, shift_en, count, valid, acc_en, out_push, busy, primed
`ifdef FIR_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    modport slave (
        output enable, flush, in_empty, out_full,
        input  PullOut, shift_en, count, valid, acc_en, out_push, busy, primed
`ifdef FIR_STALL_CNT_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM for the symmetric 29-tap complex FIR datapath.
// Pulls samples from the input FIFO into the delay line; once TAPS samples are
// in the line, every pull runs NUM_PHASES datapath phases, one accumulate
// cycle and one output-FIFO push.
// Ports:
//   Clk    : clock, all logic on posedge
//   Reset  : synchronous, active-low
//   bus    : fir_sequencer_if.master (enable, flush, in_empty, out_full in;
//            PullOut, shift_en, count, valid, acc_en, out_push, busy, primed out)
// Optional macro FIR_STALL_CNT_EN: adds stall_cnt, a saturating count of cycles
// spent in PUSH with the output FIFO full, cleared only by Reset.
module fir_sequencer #(
    parameter int unsigned TAPS       = 29,
    parameter int unsigned NUM_PHASES = 3
`ifdef FIR_STALL_CNT_EN
    ,
    parameter int unsigned STALL_W    = 16
`endif
) (
    input logic                  Clk,
    input logic                  Reset,
    fir_sequencer_if.master      bus
);
    localparam int unsigned FILL_W = $clog2(TAPS + 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StPull = 3'd1;
    localparam logic [2:0] StCalc = 3'd2;
    localparam logic [2:0] StSum  = 3'd3;
    localparam logic [2:0] StPush = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        // count rests at 0 everywhere except while stepping through CALC
        count_d = 2'd0;
        case (state_q)
            StIdle: begin
                if (bus.enable && !bus.in_empty) state_d = StPull;
            end
            StPull: begin
                if (fill_q != FILL_W'(TAPS)) fill_d = fill_q + 1'b1;
                state_d = (fill_d == FILL_W'(TAPS)) ? StCalc : StIdle;
            end
            StCalc: begin
                if (count_q == 2'(NUM_PHASES - 1)) state_d = StSum;
                else                               count_d = count_q + 2'd1;
            end
            StSum: state_d = StPush;
            StPush: begin
                if (!bus.out_full) begin
                    state_d = (bus.enable && !bus.in_empty) ? StPull : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // flush discards the line contents and any in-flight output
        if (bus.flush) begin
            state_d = StIdle;
            fill_d  = '0;
            count_d = 2'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StIdle;
            fill_q  <= '0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            count_q <= count_d;
        end
    end

    // Outputs decode the registered state, so the reset cycle shows no strobe
    assign bus.PullOut  = (state_q == StPull);
    assign bus.shift_en = (state_q == StPull);
    assign bus.valid    = (state_q == StCalc);
    assign bus.count    = count_q;
    assign bus.acc_en   = (state_q == StSum);
    assign bus.out_push = (state_q == StPush) && !bus.out_full;
    assign bus.busy     = (state_q != StIdle);
    assign bus.primed   = (fill_q == FILL_W'(TAPS));

`ifdef FIR_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            stall_q <= '0;
        end else if ((state_q == StPush) && bus.out_full && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif
endmodule
